// File: rtl/reaction_lcd_writer.sv
// Writes a 16-bit reaction time as five ASCII digits to an HD44780 LCD (8-bit bus).
// Define LCD_WRITER_INIT_EN to send the LCD init sequence on the first transaction after reset.
module reaction_lcd_writer #(
    parameter int unsigned EN_HIGH_CYCLES = 25,
    parameter int unsigned SETTLE_CYCLES  = 2500,
    parameter int unsigned CLEAR_CYCLES   = 82000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [7:0]  lcd_data,
    output logic        lcd_rs,
    output logic        lcd_en
);

    localparam int unsigned MAX_A   = (EN_HIGH_CYCLES > SETTLE_CYCLES) ? EN_HIGH_CYCLES : SETTLE_CYCLES;
    localparam int unsigned MAX_B   = (MAX_A > CLEAR_CYCLES) ? MAX_A : CLEAR_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_B > 16) ? MAX_B : 16;
    localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] EN_LAST     = CNT_W'(EN_HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONV_LAST   = CNT_W'(15);
`ifdef LCD_WRITER_INIT_EN
    localparam logic [CNT_W-1:0] CLEAR_LAST  = CNT_W'(CLEAR_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, INIT, CONVERT, SETUP, STROBE, HOLD, FIN} state_t;
`else
    typedef enum logic [2:0] {IDLE, CONVERT, SETUP, STROBE, HOLD, FIN} state_t;
`endif

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, hold_last;
    logic [2:0]       idx, idx_next;
    logic [15:0]      bin;
    logic [19:0]      bcd, adj;
    logic [3:0]       digit;
    logic [7:0]       sel_byte;
    logic             sel_rs;
    logic             latch, conv_step, load_byte;
`ifdef LCD_WRITER_INIT_EN
    logic             init_done, init_phase, init_fin;
`endif

    assign busy   = (state != IDLE) && (state != FIN);
    assign done   = (state == FIN);
    assign lcd_en = (state == STROBE);

    // Double-dabble correction: any BCD digit >= 5 gets +3 before the shift.
    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        digit = 4'd0;
        case (idx_next)
            3'd1:    digit = bcd[19:16];
            3'd2:    digit = bcd[15:12];
            3'd3:    digit = bcd[11:8];
            3'd4:    digit = bcd[7:4];
            3'd5:    digit = bcd[3:0];
            default: digit = 4'd0;
        endcase
        sel_byte = (idx_next == 3'd0) ? 8'h80 : {4'h3, digit};
        sel_rs   = (idx_next != 3'd0);
`ifdef LCD_WRITER_INIT_EN
        if (init_phase) begin
            sel_rs = 1'b0;
            case (idx_next)
                3'd0:    sel_byte = 8'h38;
                3'd1:    sel_byte = 8'h0C;
                3'd2:    sel_byte = 8'h06;
                default: sel_byte = 8'h01;
            endcase
        end
`endif
    end

    always_comb begin
`ifdef LCD_WRITER_INIT_EN
        hold_last = (lcd_data == 8'h01 && !lcd_rs) ? CLEAR_LAST : SETTLE_LAST;
`else
        hold_last = SETTLE_LAST;
`endif
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + 1'b1;
        idx_next   = idx;
        latch      = 1'b0;
        conv_step  = 1'b0;
        load_byte  = 1'b0;
`ifdef LCD_WRITER_INIT_EN
        init_fin   = 1'b0;
`endif
        case (state)
            IDLE: begin
                cnt_next = '0;
                if (start) begin
                    latch      = 1'b1;
                    idx_next   = 3'd0;
`ifdef LCD_WRITER_INIT_EN
                    state_next = init_done ? CONVERT : INIT;
`else
                    state_next = CONVERT;
`endif
                end
            end
`ifdef LCD_WRITER_INIT_EN
            INIT: begin
                cnt_next   = '0;
                load_byte  = 1'b1;
                state_next = SETUP;
            end
`endif
            CONVERT: begin
                conv_step = 1'b1;
                // Byte 0 is the fixed cursor command, so it can load while the last shift completes.
                if (cnt == CONV_LAST) begin
                    cnt_next   = '0;
                    load_byte  = 1'b1;
                    state_next = SETUP;
                end
            end
            SETUP: begin
                cnt_next   = '0;
                state_next = STROBE;
            end
            STROBE: begin
                if (cnt == EN_LAST) begin
                    cnt_next   = '0;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (cnt == hold_last) begin
                    cnt_next = '0;
`ifdef LCD_WRITER_INIT_EN
                    if (init_phase && idx == 3'd3) begin
                        init_fin   = 1'b1;
                        idx_next   = 3'd0;
                        state_next = CONVERT;
                    end else
`endif
                    if (idx == 3'd5) begin
                        state_next = FIN;
                    end else begin
                        idx_next   = idx + 3'd1;
                        load_byte  = 1'b1;
                        state_next = SETUP;
                    end
                end
            end
            FIN: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
            default: begin
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            idx      <= '0;
            bin      <= '0;
            bcd      <= '0;
            lcd_data <= '0;
            lcd_rs   <= 1'b0;
        end else begin
            cnt <= cnt_next;
            idx <= idx_next;
            if (latch) begin
                bin <= value;
                bcd <= '0;
            end else if (conv_step) begin
                bcd <= {adj[18:0], bin[15]};
                bin <= {bin[14:0], 1'b0};
            end
            if (load_byte) begin
                lcd_data <= sel_byte;
                lcd_rs   <= sel_rs;
            end
        end
    end

`ifdef LCD_WRITER_INIT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            init_done  <= 1'b0;
            init_phase <= 1'b0;
        end else if (latch && !init_done) begin
            init_phase <= 1'b1;
        end else if (init_fin) begin
            init_phase <= 1'b0;
            init_done  <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_reaction_lcd_writer.sv
// Scoreboard bench for reaction_lcd_writer: expected LCD bytes are queued at start
// and compared on each lcd_en rising edge; also checks busy length, done and reset.
module tb_reaction_lcd_writer;

    localparam int unsigned EN  = 2;
    localparam int unsigned SET = 3;
    localparam int unsigned CLR = 5;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [15:0] value;
    logic        busy, done, lcd_rs, lcd_en;
    logic [7:0]  lcd_data;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int en_rises = 0;
    bit need_init = 1'b1;
    bit cur_init = 1'b0;
    logic [8:0] sb[$];

    reaction_lcd_writer #(
        .EN_HIGH_CYCLES(EN),
        .SETTLE_CYCLES (SET),
        .CLEAR_CYCLES  (CLR)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .value   (value),
        .busy    (busy),
        .done    (done),
        .lcd_data(lcd_data),
        .lcd_rs  (lcd_rs),
        .lcd_en  (lcd_en)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_busy(input bit with_init);
        int n;
        n = 16 + 6 * (1 + EN + SET);
        if (with_init) n += 1 + 4 * (1 + EN + SET) + (CLR - SET);
        return n;
    endfunction

    task automatic push_expected(input logic [15:0] v);
        int d;
        cur_init = 1'b0;
`ifdef LCD_WRITER_INIT_EN
        if (need_init) begin
            sb.push_back({1'b0, 8'h38});
            sb.push_back({1'b0, 8'h0C});
            sb.push_back({1'b0, 8'h06});
            sb.push_back({1'b0, 8'h01});
            cur_init = 1'b1;
        end
`endif
        need_init = 1'b0;
        sb.push_back({1'b0, 8'h80});
        d = 10000;
        for (int k = 0; k < 5; k++) begin
            sb.push_back({1'b1, 8'h30 + 8'((int'(v) / d) % 10)});
            d = d / 10;
        end
    endtask

    // Called at a negedge; returns one negedge later with the request taken.
    task automatic drive_start(input logic [15:0] v);
        push_expected(v);
        busy_cnt = 0;
        done_cnt = 0;
        en_rises = 0;
        start = 1'b1;
        value = v;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns at the negedge inside the FIN cycle.
    task automatic wait_done(input bit repulse);
        int cyc = 1;
        while (!done && cyc < 4000) begin
            start = repulse && (cyc == 5 || cyc == 30);
            if (start) value = 16'd999;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 0, 1);
    endtask

    task automatic finish_txn();
        @(negedge clk);
        @(negedge clk);
        check("queue_empty", sb.size(), 0);
        check("busy_cycles", busy_cnt, exp_busy(cur_init));
        check("done_pulses", done_cnt, 1);
    endtask

    initial begin
        logic [8:0] held = '0;
        logic [8:0] exp;
        bit prev_en = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_en = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done) begin
                    done_cnt++;
                    check("fin_busy", busy, 0);
                end
                if (lcd_en && !prev_en) begin
                    en_rises++;
                    if (sb.size() == 0) begin
                        check("sb_underflow", sb.size(), 1);
                    end else begin
                        exp = sb.pop_front();
                        check("byte", {lcd_rs, lcd_data}, exp);
                    end
                    held = {lcd_rs, lcd_data};
                end
                if (busy && !lcd_en && prev_en) check("stable", {lcd_rs, lcd_data}, held);
                prev_en = lcd_en;
            end
        end
    end

    initial begin
        int budget;
        reset = 1'b1;
        start = 1'b0;
        value = '0;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_en", lcd_en, 0);
        check("rst_rs", lcd_rs, 0);
        check("rst_data", lcd_data, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;

        drive_start(16'd12345);
        wait_done(1'b0);
        finish_txn();

        drive_start(16'd0);
        wait_done(1'b0);
        finish_txn();

        // start during FIN must be ignored, then accepted in the following IDLE cycle
        drive_start(16'd65535);
        wait_done(1'b0);
        start = 1'b1;
        value = 16'd7;
        @(negedge clk);
        check("fin_start_ignored", busy, 0);
        check("queue_empty", sb.size(), 0);
        check("busy_cycles", busy_cnt, exp_busy(cur_init));
        check("done_pulses", done_cnt, 1);
        drive_start(16'd7);
        check("idle_start_taken", busy, 1);
        wait_done(1'b0);
        finish_txn();

        drive_start(16'd12345);
        wait_done(1'b1);
        finish_txn();

        // reset in the middle of the third strobe
        drive_start(16'd12345);
        budget = 0;
        while (en_rises < 3 && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        check("third_byte_seen", en_rises, 3);
        #2;
        check("pre_rst_en", lcd_en, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_en", lcd_en, 0);
        check("mid_rst_rs", lcd_rs, 0);
        check("mid_rst_data", lcd_data, 0);
        sb.delete();
        need_init = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        drive_start(16'd42);
        wait_done(1'b0);
        finish_txn();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
